rx_byte_fifo: RTL and testbench

Receive-side buffer sitting directly downstream of the half-duplex UART. It captures each received character from the UART's 1-byte output register, pulses the UART flag acknowledge, and pushes the byte into a first-word-fall-through FIFO. It counts every character lost to FIFO overflow, UART overrun or frame error. The host or character layer pops bytes at its own pace, so the UART buffer is released within 3 cycles of a character completing.

---
 rtl/rx_byte_fifo_pkg.sv | 26 ++
 rtl/rx_byte_fifo_if.sv | 48 ++++
 rtl/rx_byte_fifo_mem.sv | 48 ++++
 rtl/rx_byte_fifo.sv | 180 ++++++++++++++++++
 tb/tb_rx_byte_fifo.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/rx_byte_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_byte_fifo_pkg
// Description : Shared types and constants for the UART receive byte FIFO.
//               - FSM state encoding for the capture controller.
//               - ENTRY_W: FIFO entry width. It is 9 bits {frame_err, byte}
//                 when RX_FIFO_ERR_TAG_EN is defined, and 8 bits otherwise.
// Macro       : RX_FIFO_ERR_TAG_EN (optional frame-error tagging of entries)
// Revision    : 1.0 - initial release
// ============================================================================
package rx_byte_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CAPTURE  = 2'b01,
    WAIT_CLR = 2'b10
  } rx_state_e;

`ifdef RX_FIFO_ERR_TAG_EN
  localparam int ENTRY_W = 9;
`else
  localparam int ENTRY_W = 8;
`endif

endpackage : rx_byte_fifo_pkg
`default_nettype wire

// File: rtl/rx_byte_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_byte_fifo_if
// Description : Bundle holding the UART-side and host-side signals of
//               rx_byte_fifo.
//               master : environment view. It drives the UART byte and flags,
//                        popData and clearDrop.
//               slave  : FIFO view. It drives ackFlags and the head, status
//                        and drop-count outputs.
// Parameters  : DEPTH_LOG2 (count width - 1), DROP_CNT_WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_byte_fifo_if #(
  parameter int DEPTH_LOG2     = 3,
  parameter int DROP_CNT_WIDTH = 8
);

  // UART side
  logic [7:0]                rxData;
  logic                      dataOutReadyFlag;
  logic                      frameErrorFlag;
  logic                      overrunErrorFlag;
  logic                      ackFlags;

  // Host side
  logic                      popData;
  logic [7:0]                dataOut;
  logic                      dataOutErr;
  logic                      empty;
  logic                      full;
  logic [DEPTH_LOG2:0]       count;
  logic [DROP_CNT_WIDTH-1:0] dropCount;
  logic                      clearDrop;

  modport master (
    output rxData, dataOutReadyFlag, frameErrorFlag, overrunErrorFlag,
    output popData, clearDrop,
    input  ackFlags, dataOut, dataOutErr, empty, full, count, dropCount
  );

  modport slave (
    input  rxData, dataOutReadyFlag, frameErrorFlag, overrunErrorFlag,
    input  popData, clearDrop,
    output ackFlags, dataOut, dataOutErr, empty, full, count, dropCount
  );

endinterface : rx_byte_fifo_if
`default_nettype wire

// File: rtl/rx_byte_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : rx_fifo_mem
// Description : Storage array of 2**DEPTH_LOG2 entries of WIDTH bits, with
//               synchronous write and asynchronous (combinational) read.
//               Pointers live in the parent.
// Ports       : clk      - clock
//               wr_en    - write strobe
//               wr_addr  - write pointer
//               wr_data  - write entry
//               rd_addr  - read pointer
//               rd_data  - entry at rd_addr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module rx_fifo_mem #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 2**DEPTH_LOG2;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // The array is not reset. Readers never see stale data, because the parent
  // masks the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule : rx_fifo_mem
`default_nettype wire

// File: rtl/rx_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rx_byte_fifo
// Description : Receive buffer placed behind the UART. It captures each
//               received character, pulses ackFlags to release the UART
//               register, and pushes the byte into a first-word-fall-through
//               FIFO. Characters lost to overflow, overrun or (untagged)
//               frame error are counted in a saturating dropCount.
// Ports       : clk    - system clock (shared with the UART)
//               nReset - asynchronous active-low reset
//               bus    - rx_byte_fifo_if.slave (UART flags/byte, ackFlags,
//                        popData, dataOut/dataOutErr, empty/full/count,
//                        dropCount, clearDrop)
// Macro       : RX_FIFO_ERR_TAG_EN - store frame-errored characters tagged
//               with their error bit instead of dropping them.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_byte_fifo
  import rx_byte_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2     = 3,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic          clk,
  input  logic          nReset,
  rx_byte_fifo_if.slave bus
);

  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  rx_state_e state_q, state_d;
  logic      capture;

  logic [DEPTH_LOG2-1:0]     wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]       count_q, count_d;
  logic                      empty_q, empty_d;
  logic                      full_q, full_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  logic                      push_req;
  logic                      push_ok;
  logic                      pop_ok;
  logic [1:0]                drop_inc;
  logic [DROP_CNT_WIDTH:0]   drop_sum;
  logic [ENTRY_W-1:0]        wr_data;
  logic [ENTRY_W-1:0]        rd_data;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.dataOutReadyFlag || bus.frameErrorFlag) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d = WAIT_CLR;
      end
      WAIT_CLR: begin
        // Hold off until the UART has actually dropped every flag, so a slow
        // flag clear cannot trigger a second capture of the same character.
        if (!(bus.dataOutReadyFlag || bus.frameErrorFlag || bus.overrunErrorFlag)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    capture      = (state_q == CAPTURE);
    bus.ackFlags = capture;
  end

  // ------------------------------------------------- entry format / config
`ifdef RX_FIFO_ERR_TAG_EN
  assign push_req       = capture;
  assign wr_data        = {bus.frameErrorFlag, bus.rxData};
  assign bus.dataOutErr = ~empty_q & rd_data[ENTRY_W-1];
`else
  // Frame-errored characters are acknowledged but never stored. They fall
  // through to the rejected-push path and are counted as lost.
  assign push_req       = capture & ~bus.frameErrorFlag;
  assign wr_data        = bus.rxData;
  assign bus.dataOutErr = 1'b0;
`endif

  // A full FIFO still accepts a push when a pop frees the head in the same cycle.
  assign pop_ok  = bus.popData & ~empty_q;
  assign push_ok = push_req & (~full_q | pop_ok);

  // ----------------------------------------------------- pointers / count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_COUNT);
  end

  // ------------------------------------------------------ drop counter
  // One capture can lose the character twice over: the push is rejected and
  // the UART also reported an overrun. Both losses are counted.
  always_comb begin
    drop_inc = {1'b0, capture & ~push_ok} + {1'b0, capture & bus.overrunErrorFlag};
    drop_sum = {1'b0, drop_q} + {{(DROP_CNT_WIDTH-1){1'b0}}, drop_inc};
    if (bus.clearDrop) begin
      drop_d = '0;
    end else if (drop_sum[DROP_CNT_WIDTH]) begin
      drop_d = '1;
    end else begin
      drop_d = drop_sum[DROP_CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      drop_q   <= drop_d;
    end
  end

  // ------------------------------------------------------------ storage
  rx_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // The head is masked while the FIFO is empty, so dataOut reads 0 after reset.
  assign bus.dataOut   = empty_q ? 8'h00 : rd_data[7:0];
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.count     = count_q;
  assign bus.dropCount = drop_q;

endmodule : rx_byte_fifo
`default_nettype wire

// File: tb/tb_rx_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_byte_fifo
// Description : Testbench for rx_byte_fifo. Each character the stimulus
//               expects to be stored is queued as {err, byte}. A negedge
//               monitor compares every popped head entry with the queue front.
//               Status outputs are compared in the stimulus flow.
// Macro       : RX_FIFO_ERR_TAG_EN selects the matching expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_byte_fifo;

  logic clk = 1'b0;
  logic nReset;
  always #5 clk = ~clk;

  rx_byte_fifo_if #(.DEPTH_LOG2(3), .DROP_CNT_WIDTH(8)) bus ();

  rx_byte_fifo #(.DEPTH_LOG2(3), .DROP_CNT_WIDTH(8)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus.slave)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [8:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop is compared against the scoreboard front.
  always @(negedge clk) begin
    if (nReset && bus.popData && !bus.empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got 0x%0h expected no entry", {bus.dataOutErr, bus.dataOut});
      end else begin
        chk("pop_data", {23'b0, bus.dataOutErr, bus.dataOut}, {23'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  // The flag rises in cycle N. ackFlags is expected in N+1 only. The flags are
  // held for 'hold' extra cycles, then cleared. The task returns at the
  // negedge of the clear cycle.
  task automatic send_char(input logic [7:0] d, input bit fe, input bit ovr,
                           input bit pop_cap, input bit clr_cap, input int hold);
    @(posedge clk); #1;
    bus.rxData           = d;
    bus.dataOutReadyFlag = 1'b1;
    bus.frameErrorFlag   = fe;
    bus.overrunErrorFlag = ovr;
    @(negedge clk); chk("ack_early", bus.ackFlags, 0);
    @(posedge clk); #1;
    bus.popData   = pop_cap;
    bus.clearDrop = clr_cap;
    @(negedge clk); chk("ack_pulse", bus.ackFlags, 1);
    @(posedge clk); #1;
    bus.popData   = 1'b0;
    bus.clearDrop = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); chk("ack_single", bus.ackFlags, 0);
      @(posedge clk); #1;
    end
    bus.dataOutReadyFlag = 1'b0;
    bus.frameErrorFlag   = 1'b0;
    bus.overrunErrorFlag = 1'b0;
    @(negedge clk); chk("ack_low", bus.ackFlags, 0);
  endtask

  task automatic pop_n(input int n);
    @(posedge clk); #1;
    bus.popData = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    bus.popData = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_drop();
    @(posedge clk); #1;
    bus.clearDrop = 1'b1;
    @(posedge clk); #1;
    bus.clearDrop = 1'b0;
    @(negedge clk); chk("drop_cleared", bus.dropCount, 0);
  endtask

  task automatic fill8();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(9'(i));
      send_char(8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  initial begin
    bus.rxData = 8'h00;
    bus.dataOutReadyFlag = 1'b0;
    bus.frameErrorFlag = 1'b0;
    bus.overrunErrorFlag = 1'b0;
    bus.popData = 1'b0;
    bus.clearDrop = 1'b0;
    nReset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", bus.ackFlags, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_drop", bus.dropCount, 0);
    chk("rst_dout", bus.dataOut, 0);
    chk("rst_derr", bus.dataOutErr, 0);
    nReset = 1'b1;

    // Single character: visible in N+2, then popped.
    exp_q.push_back(9'h0A5);
    send_char(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t1_dout", bus.dataOut, 8'hA5);
    chk("t1_empty", bus.empty, 0);
    chk("t1_count", bus.count, 1);
    pop_n(1);
    chk("t1_empty_after_pop", bus.empty, 1);

    // Fill to full. The ninth character is dropped.
    fill8();
    chk("t2_full", bus.full, 1);
    chk("t2_count", bus.count, 8);
    send_char(8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t2_drop", bus.dropCount, 1);
    chk("t2_count_kept", bus.count, 8);
    pop_n(8);
    chk("t2_empty", bus.empty, 1);
    chk("t2_not_full", bus.full, 0);
    clear_drop();

    // Full FIFO with a pop in the capture cycle: the push is accepted.
    fill8();
    exp_q.push_back(9'h008);
    send_char(8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("t3_count", bus.count, 8);
    chk("t3_full", bus.full, 1);
    chk("t3_head", bus.dataOut, 8'h01);
    chk("t3_drop", bus.dropCount, 0);
    pop_n(8);
    chk("t3_empty", bus.empty, 1);

    // Frame-errored character.
`ifdef RX_FIFO_ERR_TAG_EN
    exp_q.push_back({1'b1, 8'h3C});
    send_char(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("t4_derr", bus.dataOutErr, 1);
    chk("t4_dout", bus.dataOut, 8'h3C);
    chk("t4_drop", bus.dropCount, 0);
    pop_n(1);
`else
    send_char(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("t4_empty", bus.empty, 1);
    chk("t4_drop", bus.dropCount, 1);
    chk("t4_derr", bus.dataOutErr, 0);
    clear_drop();
`endif

    // Slow flag clear: exactly one entry and one ack.
    exp_q.push_back(9'h05A);
    send_char(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    chk("t5_count", bus.count, 1);
    pop_n(1);
    chk("t5_empty", bus.empty, 1);

    // Saturation: with the FIFO full, each overrun character adds 2.
    fill8();
    for (int i = 0; i < 127; i++) begin
      send_char(8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      if (i == 0) chk("t6_drop_plus2", bus.dropCount, 2);
    end
    chk("t6_drop_254", bus.dropCount, 254);
    send_char(8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("t6_drop_sat", bus.dropCount, 255);
    send_char(8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t6_drop_hold", bus.dropCount, 255);
    send_char(8'hEE, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    chk("t6_clear_prio", bus.dropCount, 0);
    chk("t6_count", bus.count, 8);
    pop_n(8);
    chk("t6_empty", bus.empty, 1);

    // Asynchronous reset mid-operation, then a character pending at release.
    exp_q.push_back(9'h077);
    send_char(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    #2;
    nReset = 1'b0;
    #1;
    chk("t7_rst_empty", bus.empty, 1);
    chk("t7_rst_count", bus.count, 0);
    chk("t7_rst_dout", bus.dataOut, 0);
    exp_q.delete();
    bus.rxData = 8'h99;
    bus.dataOutReadyFlag = 1'b1;
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk); chk("t7_ack", bus.ackFlags, 1);
    @(posedge clk); #1;
    bus.dataOutReadyFlag = 1'b0;
    @(negedge clk);
    chk("t7_dout", bus.dataOut, 8'h99);
    chk("t7_count", bus.count, 1);
    exp_q.push_back(9'h099);
    pop_n(1);
    chk("t7_empty", bus.empty, 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rx_byte_fifo
`default_nettype wire
